// File: rtl/mux_share_arbiter.sv
// Round-robin owner of one registered 2-to-1 mux channel shared by requesters X and Y.
// A per-grant transfer limit hands the channel over when the other side is waiting.
module mux_share_arbiter #(
    parameter int W        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_x,
    input  logic         req_y,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         gnt_x,
    output logic         gnt_y,
    output logic         s,
    output logic [W-1:0] m,
    output logic         m_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_X = 2'd1,
        GRANT_Y = 2'd2
    } state_t;

    localparam logic [8:0] MAX_HOLD_9 = 9'(MAX_HOLD);
    localparam logic [7:0] HOLD_SAT   = 8'(MAX_HOLD - 1);

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic [7:0]     hold_q, hold_d;
    logic [W-1:0]   m_q, m_d;
    logic           m_valid_q, m_valid_d;

    logic           own_req;
    logic           oth_req;
    logic [8:0]     hold_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= 8'd0;
            m_q       <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            m_q       <= m_d;
            m_valid_q <= m_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        m_d       = m_q;
        m_valid_d = 1'b0;
        // Nine bits so MAX_HOLD = 255 compares without wrapping.
        hold_inc  = {1'b0, hold_q} + 9'd1;
        own_req   = (state_q == GRANT_Y) ? req_y : req_x;
        oth_req   = (state_q == GRANT_Y) ? req_x : req_y;

        case (state_q)
            IDLE: begin
                if (req_x && req_y) begin
                    state_d = last_q ? GRANT_X : GRANT_Y;
                    last_d  = ~last_q;
                    hold_d  = 8'd0;
                end else if (req_x) begin
                    state_d = GRANT_X;
                    last_d  = 1'b0;
                    hold_d  = 8'd0;
                end else if (req_y) begin
                    state_d = GRANT_Y;
                    last_d  = 1'b1;
                    hold_d  = 8'd0;
                end
            end
            GRANT_X, GRANT_Y: begin
                if (!own_req) begin
                    hold_d = 8'd0;
                    if (oth_req) begin
                        state_d = (state_q == GRANT_X) ? GRANT_Y : GRANT_X;
                        last_d  = (state_q == GRANT_X);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    m_valid_d = 1'b1;
                    m_d       = (state_q == GRANT_Y) ? y : x;
                    if (oth_req && (hold_inc == MAX_HOLD_9)) begin
                        // Limit reached with the other side waiting: this transfer is the last one.
                        state_d = (state_q == GRANT_X) ? GRANT_Y : GRANT_X;
                        last_d  = (state_q == GRANT_X);
                        hold_d  = 8'd0;
                    end else if (hold_inc >= MAX_HOLD_9) begin
                        hold_d = HOLD_SAT;
                    end else begin
                        hold_d = hold_inc[7:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_x   = (state_q == GRANT_X);
    assign gnt_y   = (state_q == GRANT_Y);
    assign s       = (state_q == GRANT_Y);
    assign m       = m_q;
    assign m_valid = m_valid_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Drives two arbiters (MAX_HOLD = 4 and MAX_HOLD = 1) from shared stimulus and
// checks every output after each edge against a transfer-counting reference model.
module tb_mux_share_arbiter;

    logic       clock;
    logic       reset;
    logic       req_x;
    logic       req_y;
    logic [3:0] x;
    logic [3:0] y;

    logic [1:0] gx;
    logic [1:0] gy;
    logic [1:0] ss;
    logic [1:0] mv;
    logic [3:0] mm [2];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: owner 0 = nobody, 1 = X, 2 = Y; streak counts
    // transfers completed during the current grant.
    int       owner  [2];
    int       last   [2];
    int       streak [2];
    int       m_exp  [2];
    int       mv_exp [2];
    const int hold_lim [2] = '{4, 1};

    mux_share_arbiter #(.W(4), .MAX_HOLD(4)) dut4 (
        .clock(clock), .reset(reset), .req_x(req_x), .req_y(req_y),
        .x(x), .y(y), .gnt_x(gx[0]), .gnt_y(gy[0]), .s(ss[0]),
        .m(mm[0]), .m_valid(mv[0])
    );

    mux_share_arbiter #(.W(4), .MAX_HOLD(1)) dut1 (
        .clock(clock), .reset(reset), .req_x(req_x), .req_y(req_y),
        .x(x), .y(y), .gnt_x(gx[1]), .gnt_y(gy[1]), .s(ss[1]),
        .m(mm[1]), .m_valid(mv[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_tick(input int k);
        int mine;
        int other;
        if (reset) begin
            owner[k] = 0; last[k] = 2; streak[k] = 0; m_exp[k] = 0; mv_exp[k] = 0;
            return;
        end
        mv_exp[k] = 0;
        if (owner[k] == 0) begin
            if (req_x && req_y)  owner[k] = (last[k] == 2) ? 1 : 2;
            else if (req_x)      owner[k] = 1;
            else if (req_y)      owner[k] = 2;
            if (owner[k] != 0) begin
                last[k]   = owner[k];
                streak[k] = 0;
            end
        end else begin
            mine  = (owner[k] == 1) ? int'(req_x) : int'(req_y);
            other = (owner[k] == 1) ? int'(req_y) : int'(req_x);
            if (mine == 0) begin
                streak[k] = 0;
                if (other != 0) begin
                    owner[k] = 3 - owner[k];
                    last[k]  = owner[k];
                end else begin
                    owner[k] = 0;
                end
            end else begin
                m_exp[k]  = (owner[k] == 1) ? int'(x) : int'(y);
                mv_exp[k] = 1;
                streak[k]++;
                if (other != 0 && streak[k] >= hold_lim[k]) begin
                    owner[k]  = 3 - owner[k];
                    last[k]   = owner[k];
                    streak[k] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s[mh=%0d] observed=%0h expected=%0h", tag, hold_lim[k], obs, expv);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("gnt_x",   k, 8'(gx[k]), 8'(owner[k] == 1));
            chk("gnt_y",   k, 8'(gy[k]), 8'(owner[k] == 2));
            chk("s",       k, 8'(ss[k]), 8'(owner[k] == 2));
            chk("m",       k, 8'(mm[k]), 8'(m_exp[k]));
            chk("m_valid", k, 8'(mv[k]), 8'(mv_exp[k]));
            chk("exclusive", k, 8'(gx[k] & gy[k]), 8'd0);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_tick(0);
        model_tick(1);
        #1;
        check_all();
        $display("edge rst=%0b rx=%0b ry=%0b x=%h y=%h | mh4 gx=%0b gy=%0b m=%h v=%0b | mh1 gx=%0b gy=%0b m=%h v=%0b",
                 reset, req_x, req_y, x, y, gx[0], gy[0], mm[0], mv[0], gx[1], gy[1], mm[1], mv[1]);
    endtask

    task automatic do_reset();
        reset = 1'b1; req_x = 1'b0; req_y = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_x = 1'b0; req_y = 1'b0; x = 4'h0; y = 4'h0;
        step();
        step();
        reset = 1'b0;
        step();

        // Contention with MAX_HOLD = 4: four X transfers, then Y.
        req_x = 1'b1; req_y = 1'b1; x = 4'h3; y = 4'hC;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 1) chk("tp1_gnt_x", 0, 8'(gx[0]), 8'd1);
            if (e >= 2 && e <= 5) chk("tp1_m_x", 0, 8'(mm[0]), 8'h3);
            if (e == 5) chk("tp1_gnt_y", 0, 8'(gy[0]), 8'd1);
            if (e == 6) chk("tp1_m_y", 0, 8'(mm[0]), 8'hC);
        end
        // Both drop in GRANT_Y, then a tie goes to X.
        req_x = 1'b0; req_y = 1'b0;
        step();
        chk("tp4_idle_hold_m", 0, 8'(mm[0]), 8'hC);
        req_x = 1'b1; req_y = 1'b1;
        step();
        chk("tp4_tie_to_x", 0, 8'(gx[0]), 8'd1);

        // Only Y requesting.
        do_reset();
        req_y = 1'b1; y = 4'h5;
        for (int e = 1; e <= 4; e++) step();
        chk("tp2_m_y", 0, 8'(mm[0]), 8'h5);

        // X drops while Y rises: direct handover.
        do_reset();
        req_x = 1'b1; x = 4'h9;
        step();
        step();
        req_x = 1'b0; req_y = 1'b1;
        step();
        chk("tp3_handover", 0, 8'(gy[0]), 8'd1);
        step();

        // Reset mid-transfer.
        do_reset();
        req_x = 1'b1; x = 4'hA;
        step();
        step();
        reset = 1'b1;
        step();
        chk("tp5_m_cleared", 0, 8'(mm[0]), 8'h0);
        reset = 1'b0;
        step();
        chk("tp5_regrant", 0, 8'(gx[0]), 8'd1);

        // MAX_HOLD = 1 alternation with changing data.
        do_reset();
        req_x = 1'b1; req_y = 1'b1;
        for (int e = 0; e < 8; e++) begin
            x = 4'(e); y = 4'(15 - e);
            step();
        end

        // Randomized traffic with occasional resets and mid-cycle glitches.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            req_x = ($urandom_range(0, 3) != 0);
            req_y = ($urandom_range(0, 2) != 0);
            x = 4'($urandom);
            y = 4'($urandom);
            step();
            // A request pulse that dies before the edge must be ignored.
            if ($urandom_range(0, 7) == 0) begin
                req_x = ~req_x; #2; req_x = ~req_x;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
Round-robin arbiter that shares a single registered 2-to-1 mux channel between two requesters, X and Y. It issues grants, drives the mux select s, and registers the selected data onto m with a valid strobe. A per-grant transfer limit stops one requester from holding the channel indefinitely while the other waits. It sits between two lab datapath sources and a single downstream consumer.

Parameters:
W, 4, data width of x, y, m
MAX_HOLD, 4, max consecutive transfers per grant when the other side is requesting; legal range 1..255

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_x  input  1  requester X wants the channel; level, held while it has data
req_y  input  1  requester Y wants the channel
x  input  W  requester X data
y  input  W  requester Y data
gnt_x  output  1  X owns the channel
gnt_y  output  1  Y owns the channel
s  output  1  mux select: 0 = x, 1 = y
m  output  W  registered channel data
m_valid  output  1  m holds data captured at the last edge

Behaviour:
- One clock. Reset is synchronous and active-high; all state changes occur on the rising edge of clock.
- State: IDLE, GRANT_X, GRANT_Y. Internal regs: last (0 = X, 1 = Y) and hold_cnt (8 bits).
- Reset values: state = IDLE, gnt_x = 0, gnt_y = 0, s = 0, m = 0, m_valid = 0, last = 1 (X wins the first tie), hold_cnt = 0.
- Moore outputs: gnt_x = (state == GRANT_X); gnt_y = (state == GRANT_Y); s = (state == GRANT_Y).
- Transfer: an X transfer is a cycle with gnt_x & req_x, sampled at the edge. Y is symmetric.
  - On a transfer edge: m <= selected data, m_valid <= 1.
  - Otherwise: m_valid <= 0 and m holds its value.
  - Latency from sampled data to m is one cycle.
- IDLE transitions:
  - req_x & req_y: grant the side that is not last.
  - Only req_x: GRANT_X. Only req_y: GRANT_Y. Neither: stay in IDLE.
  - When IDLE is left, last is set to the granted side and hold_cnt is set to 0.
- GRANT_X transitions (GRANT_Y mirrors these):
  - req_x = 0: go to GRANT_Y if req_y, else IDLE. No transfer occurs.
  - req_x = 1 and hold_cnt + 1 == MAX_HOLD and req_y = 1: the transfer completes, then go to GRANT_Y.
  - Otherwise: stay; hold_cnt increments and saturates at MAX_HOLD - 1.
  - A saturated counter with req_y = 0 keeps the grant with no limit.
- Every grant change clears hold_cnt and updates last. A direct switch between grants inserts no IDLE bubble.
- The grant can never be asserted to both sides; gnt_x & gnt_y = 0 always.
- Requests are sampled only at edges. A request that rises and falls between edges is ignored.
- Reset mid-operation: at the reset edge all registers return to reset values. An in-flight transfer is discarded (m_valid = 0, m = 0).
- MAX_HOLD = 1 gives strict alternation whenever both sides request.

Test Plan:
- Reset, then req_x = req_y = 1 with x = 4'h3, y = 4'hC (MAX_HOLD = 4) -> gnt_x = 1 after edge 1; m = 3 with m_valid = 1 after edges 2–5; gnt_y = 1 after edge 5; m = C after edge 6.
- Only req_y = 1, y = 4'h5 -> IDLE→GRANT_Y at edge 1, s = 1, m = 5, m_valid = 1 after edge 2 and held thereafter; gnt_x never asserts.
- GRANT_X with req_x dropping in the same cycle req_y rises -> gnt_y = 1 at the next edge, no IDLE cycle, m_valid = 0 for that one edge.
- Both requests drop during GRANT_Y -> IDLE at next edge, m_valid = 0, m holds last y; next simultaneous request grants X (last = Y).
- Reset asserted for one edge during an X transfer -> after that edge all outputs are 0 and state is IDLE; with requests still high, gnt_x = 1 one edge after reset deasserts.
- MAX_HOLD = 1 with both requests held for 8 edges -> grants alternate X, Y, X, …; m alternates x, y values each edge; gnt_x & gnt_y is never 1.
